// File: rtl/stage_mem.sv
// stage_mem: memory pipeline stage that sits directly after execute.
//
// A non-memory instruction passes through to writeback after one register stage.
// A load or store becomes one request/acknowledge transaction on the data-memory bus.
// Upstream is held with `stall` while that transaction is outstanding.
// An access that is misaligned or otherwise illegal never reaches the bus.
// Such an access, and a bus timeout, each raise a one-cycle `mem_err`.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   valid_in            instruction presented this cycle
//   memread, memwrite   load / store flags
//   funct3              size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   aluout              effective address, or ALU result for non-memory ops
//   reg_data2           store data
//   rd_in, regwrite_in  destination register and its write enable
//   stall               hold upstream (combinational)
//   dmem_*              data-memory bus (req/we/addr/wdata/be registered)
//   dmem_ack,rdata      bus completion; rdata is valid in the ack cycle
//   wb_*                registered writeback slot
//   mem_err             one-cycle pulse: illegal access or bus timeout
module stage_mem #(
  parameter int unsigned TIMEOUT = 16  // BUSY cycles to wait for ack, 2..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] aluout,
  input  logic [31:0] reg_data2,
  input  logic [4:0]  rd_in,
  input  logic        regwrite_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [1:0]  r_lane;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_regwrite;
  logic        r_req, r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_wb_valid, r_wb_regwrite, r_mem_err;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic        w_memop, w_size_ok, w_align_ok, w_illegal;
  logic        w_accept, w_done, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Access decode for the instruction presented in IDLE.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_memop = valid_in & (memread | memwrite);
    // Size 11 never exists.
    // The unsigned forms are load-only and exist only for B and H.
    w_size_ok = (funct3[1:0] != 2'b11) && !(funct3[2] && (memwrite || funct3[1]));
    w_align_ok = 1'b1;
    w_be       = 4'b1111;
    w_wdata    = reg_data2;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << aluout[1:0];
        w_wdata = {4{reg_data2[7:0]}};
      end
      2'b01: begin
        w_align_ok = ~aluout[0];
        w_be       = aluout[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{reg_data2[15:0]}};
      end
      2'b10: w_align_ok = (aluout[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
    w_illegal = (memread & memwrite) | ~w_size_ok | ~w_align_ok;
  end

  // Load lane selection and extension, using the access latched at acceptance.
  always_comb begin
    w_byte = dmem_rdata[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  // Next state and the combinational stall.
  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    w_accept  = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop && !w_illegal) begin
          w_accept = 1'b1;
          stall    = 1'b1;
          w_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        // Release upstream on the cycle the access finishes, whether it ends by ack or by timeout.
        stall = !dmem_ack && (r_cnt != CNT_LAST);
        if (dmem_ack) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_lane        <= '0;
      r_funct3      <= '0;
      r_rd          <= '0;
      r_regwrite    <= 1'b0;
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_regwrite <= 1'b0;
      r_wb_data     <= '0;
      r_mem_err     <= 1'b0;
    end else begin
      r_mem_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_lane        <= aluout[1:0];
            r_funct3      <= funct3;
            r_rd          <= rd_in;
            r_regwrite    <= regwrite_in;
            r_req         <= 1'b1;
            r_we          <= memwrite;
            r_addr        <= {aluout[31:2], 2'b00};
            r_wdata       <= w_wdata;
            r_be          <= w_be;
            r_cnt         <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
          end else if (w_memop) begin
            // Illegal access: answer at once with an error and no register write.
            r_mem_err     <= 1'b1;
            r_wb_valid    <= 1'b1;
            r_wb_rd       <= rd_in;
            r_wb_regwrite <= 1'b0;
            r_wb_data     <= '0;
          end else if (valid_in) begin
            r_wb_valid    <= 1'b1;
            r_wb_rd       <= rd_in;
            r_wb_regwrite <= regwrite_in;
            r_wb_data     <= aluout;
          end else begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_req         <= 1'b0;
            r_wb_valid    <= 1'b1;
            r_wb_rd       <= r_rd;
            r_wb_regwrite <= r_we ? 1'b0 : r_regwrite;
            r_wb_data     <= r_we ? 32'h0 : w_load;
          end else if (w_timeout) begin
            r_req         <= 1'b0;
            r_mem_err     <= 1'b1;
            r_wb_valid    <= 1'b1;
            r_wb_rd       <= r_rd;
            r_wb_regwrite <= 1'b0;
            r_wb_data     <= '0;
          end else begin
            r_cnt         <= r_cnt + 8'd1;
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
          end
        end
        default: r_req <= 1'b0;
      endcase
    end
  end

  assign dmem_req    = r_req;
  assign dmem_we     = r_we;
  assign dmem_addr   = r_addr;
  assign dmem_wdata  = r_wdata;
  assign dmem_be     = r_be;
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign wb_regwrite = r_wb_regwrite;
  assign wb_data     = r_wb_data;
  assign mem_err     = r_mem_err;

endmodule

// File: tb/tb_stage_mem.sv
// Testbench for stage_mem.
// It applies a table of directed vectors and a few hand-written reset sequences.
// It then applies randomized instructions.
// Each result is compared with a reference model written from the access rules.
module tb_stage_mem;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, memread, memwrite, regwrite_in, dmem_ack;
  logic [2:0]  funct3;
  logic [31:0] aluout, reg_data2, dmem_rdata;
  logic [4:0]  rd_in;
  logic        stall, dmem_req, dmem_we, wb_valid, wb_regwrite, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_rd;

  stage_mem #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .aluout(aluout), .reg_data2(reg_data2), .rd_in(rd_in),
    .regwrite_in(regwrite_in), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mr, mw;
    logic [2:0]  f3;
    logic [31:0] addr, data, rdata;
    logic [7:0]  dly;      // BUSY cycle carrying ack; 0 = never ack
    logic [4:0]  rd;
    logic        rw;
  } op_t;

  typedef struct packed {
    logic        req, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  stall_n, lat;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [7:0]  n_stall, lat;
    logic        req, we, unstable, rw, err, after_bad;
    logic [31:0] addr, wdata, data;
    logic [3:0]  be;
    logic [4:0]  rd;
  } obs_t;

  typedef struct {
    op_t  op;
    exp_t exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic op_t mk_op(logic mr, logic mw, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] data, logic [31:0] rdata, logic [7:0] dly,
                                logic [4:0] rd, logic rw);
    op_t o;
    o = '{mr:mr, mw:mw, f3:f3, addr:addr, data:data, rdata:rdata, dly:dly, rd:rd, rw:rw};
    return o;
  endfunction

  function automatic exp_t mk_exp(logic req, logic we, logic [31:0] addr, logic [3:0] be,
                                  logic [31:0] wdata, logic [7:0] st, logic [7:0] lat,
                                  logic rw, logic [4:0] rd, logic [31:0] data, logic err);
    exp_t e;
    e = '{req:req, we:we, addr:addr, be:be, wdata:wdata, stall_n:st, lat:lat,
          rw:rw, rd:rd, data:data, err:err};
    return e;
  endfunction

  // Reference model: derives the expected outcome of one instruction arithmetically from the access rules.
  function automatic exp_t model(op_t op);
    exp_t        e;
    int          sz, off, n;
    logic [31:0] mask, v;
    e = '0;
    if (!(op.mr || op.mw)) begin
      e.lat = 8'd1; e.rw = op.rw; e.rd = op.rd; e.data = op.addr;
      return e;
    end
    sz  = 1 << op.f3[1:0];
    off = int'(op.addr[1:0]);
    if ((op.mr && op.mw) || sz == 8 || (op.f3[2] && (op.mw || sz == 4)) ||
        (int'(op.addr[2:0]) % sz) != 0) begin
      e.lat = 8'd1; e.err = 1'b1; e.rd = op.rd;
      return e;
    end
    e.req  = 1'b1;
    e.we   = op.mw;
    e.addr = op.addr - 32'(off);
    e.be   = 4'(((1 << sz) - 1) << off);
    if (sz == 1)      e.wdata = {24'h0, op.data[7:0]} * 32'h0101_0101;
    else if (sz == 2) e.wdata = {16'h0, op.data[15:0]} * 32'h0001_0001;
    else              e.wdata = op.data;
    n = (op.dly >= 1 && int'(op.dly) <= TMO) ? int'(op.dly) : TMO;
    e.stall_n = 8'(n);
    e.lat     = 8'(n + 1);
    e.rd      = op.rd;
    if (op.dly == 0 || int'(op.dly) > TMO) begin
      e.err = 1'b1;
    end else if (!op.mw) begin
      e.rw = op.rw;
      mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
      v    = (op.rdata >> (8 * off)) & mask;
      if (!op.f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
      e.data = v;
    end
    return e;
  endfunction

  // Present one instruction right after a clock edge and act as the bus slave.
  // The instruction is observed until its writeback slot appears.
  // Random junk is driven on the upstream inputs while the stage is busy.
  task automatic run_op(input op_t op, output obs_t ob);
    int k;
    bit done;
    ob = '0;
    valid_in = 1'b1; memread = op.mr; memwrite = op.mw; funct3 = op.f3;
    aluout = op.addr; reg_data2 = op.data; rd_in = op.rd; regwrite_in = op.rw;
    dmem_ack = 1'($urandom_range(0, 1));  // ack outside BUSY must be ignored
    dmem_rdata = $urandom;
    k = 0;
    done = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      if (stall) ob.n_stall = ob.n_stall + 8'd1;
      if (k >= 1 && dmem_req && (dmem_addr !== ob.addr || dmem_be !== ob.be ||
                                 dmem_wdata !== ob.wdata || dmem_we !== ob.we))
        ob.unstable = 1'b1;
      @(posedge clk);
      #1;
      k++;
      if (k == 1 && dmem_req) begin
        ob.addr = dmem_addr; ob.be = dmem_be; ob.wdata = dmem_wdata; ob.we = dmem_we;
      end
      ob.req = ob.req | dmem_req;
      if (wb_valid) begin
        done = 1;
        ob.lat = 8'(k); ob.rw = wb_regwrite; ob.rd = wb_rd; ob.data = wb_data;
        ob.err = mem_err; ob.after_bad = dmem_req;
      end else begin
        valid_in = 1'($urandom_range(0, 1)); memread = 1'($urandom_range(0, 1));
        memwrite = 1'($urandom_range(0, 1)); funct3 = 3'($urandom_range(0, 7));
        aluout = $urandom; reg_data2 = $urandom; rd_in = 5'($urandom_range(0, 31));
        regwrite_in = 1'($urandom_range(0, 1));
        dmem_ack = (op.dly != 0) && (k == int'(op.dly));
        dmem_rdata = dmem_ack ? op.rdata : $urandom;
      end
    end
    valid_in = 1'b0; memread = 1'b0; memwrite = 1'b0; dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    ob.after_bad = ob.after_bad | mem_err | wb_valid | dmem_req;
  endtask

  task automatic compare(input string tag, input exp_t e, input obs_t ob);
    check({tag, " latency"}, 32'(ob.lat), 32'(e.lat));
    check({tag, " stall_cycles"}, 32'(ob.n_stall), 32'(e.stall_n));
    check({tag, " dmem_req_seen"}, 32'(ob.req), 32'(e.req));
    check({tag, " mem_err"}, 32'(ob.err), 32'(e.err));
    check({tag, " wb_regwrite"}, 32'(ob.rw), 32'(e.rw));
    check({tag, " no_lingering_pulse"}, 32'(ob.after_bad), 32'd0);
    if (e.req) begin
      check({tag, " dmem_addr"}, ob.addr, e.addr);
      check({tag, " dmem_be"}, 32'(ob.be), 32'(e.be));
      check({tag, " dmem_wdata"}, ob.wdata, e.wdata);
      check({tag, " dmem_we"}, 32'(ob.we), 32'(e.we));
      check({tag, " bus_stable"}, 32'(ob.unstable), 32'd0);
    end
    if (!e.err) begin
      check({tag, " wb_rd"}, 32'(ob.rd), 32'(e.rd));
      check({tag, " wb_data"}, ob.data, e.data);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    obs_t ob;
    op_t  op;

    tbl[0]  = '{mk_op(0,0,3'b000,32'h1234_5678,0,0,0,5,1),
                mk_exp(0,0,0,0,0,0,1,1,5,32'h1234_5678,0)};
    tbl[1]  = '{mk_op(0,1,3'b000,32'h103,32'hAABB_CCDD,0,3,7,1),
                mk_exp(1,1,32'h100,4'b1000,32'hDDDD_DDDD,3,4,0,7,0,0)};
    tbl[2]  = '{mk_op(1,0,3'b000,32'h102,0,32'h0080_0000,1,3,1),
                mk_exp(1,0,32'h100,4'b0100,0,1,2,1,3,32'hFFFF_FF80,0)};
    tbl[3]  = '{mk_op(1,0,3'b100,32'h102,0,32'h0080_0000,1,4,1),
                mk_exp(1,0,32'h100,4'b0100,0,1,2,1,4,32'h0000_0080,0)};
    tbl[4]  = '{mk_op(1,0,3'b001,32'h102,0,32'h8001_0000,1,6,1),
                mk_exp(1,0,32'h100,4'b1100,0,1,2,1,6,32'hFFFF_8001,0)};
    tbl[5]  = '{mk_op(1,0,3'b010,32'h102,0,0,1,8,1), mk_exp(0,0,0,0,0,0,1,0,8,0,1)};
    tbl[6]  = '{mk_op(1,0,3'b011,32'h100,0,0,1,8,1), mk_exp(0,0,0,0,0,0,1,0,8,0,1)};
    tbl[7]  = '{mk_op(0,1,3'b100,32'h100,0,0,1,8,1), mk_exp(0,0,0,0,0,0,1,0,8,0,1)};
    tbl[8]  = '{mk_op(1,1,3'b010,32'h100,0,0,1,8,1), mk_exp(0,0,0,0,0,0,1,0,8,0,1)};
    tbl[9]  = '{mk_op(0,1,3'b001,32'h101,0,0,1,8,1), mk_exp(0,0,0,0,0,0,1,0,8,0,1)};
    tbl[10] = '{mk_op(1,0,3'b010,32'h200,0,0,0,9,1),
                mk_exp(1,0,32'h200,4'b1111,0,16,17,0,9,0,1)};
    tbl[11] = '{mk_op(0,1,3'b010,32'h204,32'h0102_0304,0,2,10,1),
                mk_exp(1,1,32'h204,4'b1111,32'h0102_0304,2,3,0,10,0,0)};
    tbl[12] = '{mk_op(0,1,3'b001,32'h206,32'h0000_BEEF,0,1,11,1),
                mk_exp(1,1,32'h204,4'b1100,32'hBEEF_BEEF,1,2,0,11,0,0)};
    tbl[13] = '{mk_op(1,0,3'b101,32'h100,0,32'h1234_F00D,4,12,1),
                mk_exp(1,0,32'h100,4'b0011,0,4,5,1,12,32'h0000_F00D,0)};
    tbl[14] = '{mk_op(1,0,3'b010,32'h300,0,32'hCAFE_BABE,16,13,1),
                mk_exp(1,0,32'h300,4'b1111,0,16,17,1,13,32'hCAFE_BABE,0)};
    tbl[15] = '{mk_op(1,0,3'b000,32'h101,0,32'h0000_7F00,2,14,0),
                mk_exp(1,0,32'h100,4'b0010,0,2,3,0,14,32'h0000_007F,0)};

    rst = 1'b1;
    valid_in = 0; memread = 0; memwrite = 0; funct3 = 0; aluout = 0; reg_data2 = 0;
    rd_in = 0; regwrite_in = 0; dmem_ack = 0; dmem_rdata = 0;
    #2;
    check("reset dmem_req", 32'(dmem_req), 32'd0);
    check("reset wb_valid", 32'(wb_valid), 32'd0);
    check("reset wb_regwrite", 32'(wb_regwrite), 32'd0);
    check("reset mem_err", 32'(mem_err), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset dmem_be", 32'(dmem_be), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, ob);
      compare($sformatf("tbl%0d", i), tbl[i].exp, ob);
    end

    // Reset in the middle of an outstanding load: the bus and writeback outputs drop at once.
    valid_in = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010;
    aluout = 32'h400; rd_in = 5'd3; regwrite_in = 1'b1; dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    valid_in = 1'b0; memread = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("midbusy dmem_req before reset", 32'(dmem_req), 32'd1);
    check("midbusy stall before reset", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("midbusy reset dmem_req", 32'(dmem_req), 32'd0);
    check("midbusy reset wb_valid", 32'(wb_valid), 32'd0);
    check("midbusy reset stall", 32'(stall), 32'd0);
    check("midbusy reset dmem_addr", dmem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after reset stall", 32'(stall), 32'd0);
    run_op(tbl[0].op, ob);
    compare("post_reset passthrough", tbl[0].exp, ob);

    // Randomized instructions checked against the reference model.
    for (int i = 0; i < 150; i++) begin
      int r, rd2;
      r = int'($urandom_range(0, 9));
      op.mr = (r >= 2 && r < 6) || r == 2;
      op.mw = (r >= 6) || r == 2;
      if (r < 2) begin op.mr = 1'b0; op.mw = 1'b0; end
      op.f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                          : (($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2))
                                                                         : 3'($urandom_range(4, 5)));
      op.addr = $urandom;
      if ($urandom_range(0, 3) != 0)
        op.addr = op.addr & ~((32'd1 << op.f3[1:0]) - 32'd1);
      op.data  = $urandom;
      op.rdata = $urandom;
      rd2 = int'($urandom_range(0, 9));
      if (rd2 == 0)      op.dly = 8'd0;
      else if (rd2 == 1) op.dly = 8'(TMO);
      else if (rd2 == 2) op.dly = 8'(TMO - 1);
      else               op.dly = 8'($urandom_range(1, 5));
      op.rd = 5'($urandom_range(0, 31));
      op.rw = 1'($urandom_range(0, 1));
      run_op(op, ob);
      compare($sformatf("rand%0d", i), model(op), ob);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
